// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared trigger-unit types and default sizes.
//   trig_type_e : channel match type (exec / load / store / any access)
//   dbg_state_e : halt handshake state
package rv32i_pkg;
  localparam int NUM_TRIG_DEF = 4;
  localparam int TRIG_CNT_W = 16;
  typedef enum logic [1:0] {TRIG_EXEC, TRIG_LOAD, TRIG_STORE, TRIG_ANY} trig_type_e;
  typedef enum logic [1:0] {DBG_RUN, DBG_HALT_REQ, DBG_HALTED, DBG_SKIP} dbg_state_e;
endpackage

// File: rtl/rv32i_trig_channel.sv
// rv32i_trig_channel: one address/mask comparator with its hit-count threshold.
//   en, kind, addr, mask, count, load : channel configuration and counter clear
//   pc/instr_valid, mem_* : retire and data-access observation
//   active : counting allowed (RUN or SKIP); skip : exec matches suppressed
//   fire : threshold reached this cycle; cmp_a : comparator input (PC or mem_addr)
module rv32i_trig_channel
  import rv32i_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int CNT_W = TRIG_CNT_W
)(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [1:0]      kind,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] mask,
  input  logic [CNT_W-1:0] count,
  input  logic            load,
  input  logic            instr_valid,
  input  logic [XLEN-1:0] pc,
  input  logic            mem_valid,
  input  logic            mem_we,
  input  logic [XLEN-1:0] mem_addr,
  input  logic            active,
  input  logic            skip,
  output logic            fire,
  output logic [XLEN-1:0] cmp_a
);
  trig_type_e t;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W:0] nxt, thr;
  logic v, qual;
  assign t = trig_type_e'(kind);
  assign cmp_a = (t == TRIG_EXEC) ? pc : mem_addr;
  // in SKIP every exec match belongs to the stepped-over instruction, since
  // an exec match needs instr_valid and the first instr_valid leaves SKIP
  assign v = (t == TRIG_EXEC)  ? instr_valid & ~skip :
             (t == TRIG_LOAD)  ? mem_valid & ~mem_we :
             (t == TRIG_STORE) ? mem_valid & mem_we : mem_valid;
  // a same-cycle counter clear discards the match entirely
  assign qual = en & active & v & ~load & (((cmp_a ^ addr) & ~mask) == '0);
  assign nxt = {1'b0, cnt} + 1'b1;
  assign thr = (count == '0) ? (CNT_W+1)'(1) : {1'b0, count};
  assign fire = qual & (nxt >= thr);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else if (load || fire) cnt <= '0;
    else if (qual && !(&cnt)) cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/rv32i_trigger_unit.sv
// rv32i_trigger_unit: NUM_TRIG debug trigger channels plus the core halt handshake.
//   core side  : instr_valid/pc (retire), mem_valid/mem_we/mem_addr (LSU)
//   config     : trig_en, trig_type, trig_addr, trig_mask, trig_count, trig_load, status_clr
//   handshake  : halt_ack, resume_req in; halt_req, halted out
//   capture    : hit_status (sticky), hit_index / hit_addr of the last halting hit
module rv32i_trigger_unit
  import rv32i_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NUM_TRIG = NUM_TRIG_DEF,
  parameter int CNT_W = TRIG_CNT_W,
  parameter int IDX_W = (NUM_TRIG > 1) ? $clog2(NUM_TRIG) : 1
)(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     instr_valid,
  input  logic [XLEN-1:0]          pc,
  input  logic                     mem_valid,
  input  logic                     mem_we,
  input  logic [XLEN-1:0]          mem_addr,
  input  logic [NUM_TRIG-1:0]      trig_en,
  input  logic [2*NUM_TRIG-1:0]    trig_type,
  input  logic [XLEN*NUM_TRIG-1:0] trig_addr,
  input  logic [XLEN*NUM_TRIG-1:0] trig_mask,
  input  logic [CNT_W*NUM_TRIG-1:0] trig_count,
  input  logic [NUM_TRIG-1:0]      trig_load,
  input  logic [NUM_TRIG-1:0]      status_clr,
  input  logic                     halt_ack,
  input  logic                     resume_req,
  output logic                     halt_req,
  output logic                     halted,
  output logic [NUM_TRIG-1:0]      hit_status,
  output logic [IDX_W-1:0]         hit_index,
  output logic [XLEN-1:0]          hit_addr
);
  dbg_state_e state, state_nxt;
  logic [NUM_TRIG-1:0] fire;
  logic [XLEN-1:0] cmp_a [NUM_TRIG];
  logic [IDX_W-1:0] idx_nxt;
  logic [XLEN-1:0] addr_nxt;
  logic active, skip, any_fire;
  assign active = (state == DBG_RUN) || (state == DBG_SKIP);
  assign skip = state == DBG_SKIP;
  assign any_fire = |fire;
  for (genvar i = 0; i < NUM_TRIG; i++) begin : g_ch
    rv32i_trig_channel #(.XLEN(XLEN), .CNT_W(CNT_W)) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (trig_en[i]),
      .kind        (trig_type[2*i +: 2]),
      .addr        (trig_addr[XLEN*i +: XLEN]),
      .mask        (trig_mask[XLEN*i +: XLEN]),
      .count       (trig_count[CNT_W*i +: CNT_W]),
      .load        (trig_load[i]),
      .instr_valid (instr_valid),
      .pc          (pc),
      .mem_valid   (mem_valid),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .active      (active),
      .skip        (skip),
      .fire        (fire[i]),
      .cmp_a       (cmp_a[i])
    );
  end
  // scan downward so the lowest firing channel wins
  always_comb begin
    idx_nxt = '0;
    addr_nxt = cmp_a[0];
    for (int i = NUM_TRIG - 1; i >= 0; i--)
      if (fire[i]) begin
        idx_nxt = IDX_W'(i);
        addr_nxt = cmp_a[i];
      end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= DBG_RUN;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = state;
    case (state)
      DBG_RUN:      state_nxt = any_fire ? DBG_HALT_REQ : DBG_RUN;
      DBG_HALT_REQ: state_nxt = halt_ack ? DBG_HALTED : DBG_HALT_REQ;
      DBG_HALTED:   state_nxt = resume_req ? DBG_SKIP : DBG_HALTED;
      DBG_SKIP:     state_nxt = any_fire ? DBG_HALT_REQ : instr_valid ? DBG_RUN : DBG_SKIP;
      default:      state_nxt = DBG_RUN;
    endcase
  end
  always_comb begin
    halt_req = state == DBG_HALT_REQ;
    halted = state == DBG_HALTED;
  end
  // a new fire beats a same-cycle write-1-to-clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_status <= '0;
      hit_index <= '0;
      hit_addr <= '0;
    end else begin
      hit_status <= (hit_status & ~status_clr) | fire;
      if (any_fire) begin
        hit_index <= idx_nxt;
        hit_addr <= addr_nxt;
      end
    end
  end
endmodule

// File: tb/tb_rv32i_trigger_unit.sv
// tb_rv32i_trigger_unit: directed scenarios plus randomized traffic against a behavioural model.
module tb_rv32i_trigger_unit;
  localparam int M_RUN = 0, M_HREQ = 1, M_HALTED = 2, M_SKIP = 3;
  logic clk = 0, rst_n = 0;
  logic instr_valid = 0, mem_valid = 0, mem_we = 0, halt_ack = 0, resume_req = 0;
  logic [31:0] pc = 0, mem_addr = 0;
  logic [3:0] trig_en = 0, trig_load = 0, status_clr = 0;
  logic [7:0] trig_type = 0;
  logic [127:0] trig_addr = 0, trig_mask = 0;
  logic [63:0] trig_count = 0;
  logic halt_req, halted;
  logic [3:0] hit_status;
  logic [1:0] hit_index;
  logic [31:0] hit_addr;
  int nchk = 0, npass = 0;
  int ms;
  int m_cnt [4];
  logic [3:0] m_status, m_f;
  int m_idx, m_first, m_ty, m_need;
  logic [31:0] m_addr, m_a, m_ta, m_tm;
  bit m_v;
  logic [31:0] pool [8] = '{32'h100, 32'h104, 32'h200, 32'h300, 32'h8000_0044, 32'h8000_0100, 32'h8000_0000, 32'h1fc};

  rv32i_trigger_unit dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .pc(pc), .mem_valid(mem_valid),
    .mem_we(mem_we), .mem_addr(mem_addr), .trig_en(trig_en), .trig_type(trig_type),
    .trig_addr(trig_addr), .trig_mask(trig_mask), .trig_count(trig_count), .trig_load(trig_load),
    .status_clr(status_clr), .halt_ack(halt_ack), .resume_req(resume_req), .halt_req(halt_req),
    .halted(halted), .hit_status(hit_status), .hit_index(hit_index), .hit_addr(hit_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // reference: per-channel hit counts, sticky flags and the debug state, from the rules directly
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      ms = M_RUN; m_status = 0; m_idx = 0; m_addr = 0;
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    end else begin
      m_f = 0; m_first = -1;
      for (int i = 0; i < 4; i++) begin
        m_ty = int'(trig_type[2*i +: 2]);
        m_ta = trig_addr[32*i +: 32];
        m_tm = trig_mask[32*i +: 32];
        m_a = (m_ty == 0) ? pc : mem_addr;
        case (m_ty)
          0: m_v = instr_valid && ms != M_SKIP;
          1: m_v = mem_valid && !mem_we;
          2: m_v = mem_valid && mem_we;
          default: m_v = mem_valid;
        endcase
        if (ms == M_HREQ || ms == M_HALTED) m_v = 0;
        m_need = (trig_count[16*i +: 16] == 0) ? 1 : int'(trig_count[16*i +: 16]);
        if (trig_load[i]) m_cnt[i] = 0;
        else if (trig_en[i] && m_v && ((m_a & ~m_tm) == (m_ta & ~m_tm))) begin
          if (m_cnt[i] + 1 >= m_need) begin
            m_f[i] = 1; m_cnt[i] = 0;
            if (m_first < 0) begin m_first = i; m_addr = m_a; end
          end else if (m_cnt[i] < 65535) m_cnt[i]++;
        end
      end
      m_status = (m_status & ~status_clr) | m_f;
      if (m_first >= 0) m_idx = m_first;
      case (ms)
        M_RUN:    if (m_f != 0) ms = M_HREQ;
        M_HREQ:   if (halt_ack) ms = M_HALTED;
        M_HALTED: if (resume_req) ms = M_SKIP;
        default:  if (m_f != 0) ms = M_HREQ; else if (instr_valid) ms = M_RUN;
      endcase
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      chk("m_halt_req", 64'(halt_req), 64'(ms == M_HREQ));
      chk("m_halted", 64'(halted), 64'(ms == M_HALTED));
      chk("m_hit_status", 64'(hit_status), 64'(m_status));
      chk("m_hit_index", 64'(hit_index), 64'(m_idx));
      chk("m_hit_addr", 64'(hit_addr), 64'(m_addr));
    end
  end

  task automatic step();
    @(negedge clk);
    instr_valid = 0; mem_valid = 0; trig_load = 0; status_clr = 0; resume_req = 0; halt_ack = 0;
  endtask

  task automatic retire(input logic [31:0] a);
    instr_valid = 1; pc = a; step();
  endtask

  task automatic halt_and_resume();
    halt_ack = 1; step();
    resume_req = 1; step();
    retire(32'hfff0);
  endtask

  task automatic cfg(input int i, input logic [1:0] ty, input logic [31:0] a, input logic [31:0] m, input logic [15:0] c);
    trig_type[2*i +: 2] = ty; trig_addr[32*i +: 32] = a; trig_mask[32*i +: 32] = m; trig_count[16*i +: 16] = c;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_halt_req", 64'(halt_req), 0);
    chk("rst_status", 64'(hit_status), 0);
    chk("rst_addr", 64'(hit_addr), 0);
    rst_n = 1;
    // exec breakpoint and halt handshake
    cfg(0, 2'b00, 32'h100, 0, 0); trig_en = 4'b0001;
    retire(32'h100);
    chk("t1_halt_req", 64'(halt_req), 1);
    chk("t1_index", 64'(hit_index), 0);
    chk("t1_addr", 64'(hit_addr), 64'h100);
    chk("t1_status", 64'(hit_status), 64'b0001);
    halt_ack = 1; step();
    chk("t1_halted", 64'(halted), 1);
    chk("t1_req_drop", 64'(halt_req), 0);
    // step-over on resume, then the loop-back retire fires
    resume_req = 1; step();
    chk("t5_resumed", 64'(halted), 0);
    retire(32'h100);
    chk("t5_skip", 64'(halt_req), 0);
    retire(32'h100);
    chk("t5_refire", 64'(halt_req), 1);
    halt_and_resume();
    // hit-count threshold
    cfg(1, 2'b00, 32'h200, 0, 3); trig_en = 4'b0010; trig_load = 4'b1111; step();
    retire(32'h200); chk("t2_hit1", 64'(halt_req), 0);
    retire(32'h200); chk("t2_hit2", 64'(halt_req), 0);
    retire(32'h200); chk("t2_hit3", 64'(halt_req), 1);
    chk("t2_index", 64'(hit_index), 1);
    halt_and_resume();
    retire(32'h200); chk("t2_hit4", 64'(halt_req), 0);
    retire(32'h200); chk("t2_hit5", 64'(halt_req), 0);
    // masked store trigger
    cfg(2, 2'b10, 32'h8000_0000, 32'hff, 0); trig_en = 4'b0100; trig_load = 4'b1111; step();
    mem_valid = 1; mem_we = 1; mem_addr = 32'h8000_0044; step();
    chk("t3_fire", 64'(halt_req), 1);
    chk("t3_addr", 64'(hit_addr), 64'h8000_0044);
    chk("t3_index", 64'(hit_index), 2);
    halt_and_resume();
    mem_valid = 1; mem_we = 0; mem_addr = 32'h8000_0044; step();
    chk("t3_load", 64'(halt_req), 0);
    mem_valid = 1; mem_we = 1; mem_addr = 32'h8000_0100; step();
    chk("t3_far", 64'(halt_req), 0);
    // priority and set-beats-clear
    cfg(0, 2'b00, 32'h300, 0, 0); cfg(3, 2'b00, 32'h300, 0, 0); trig_en = 4'b1001;
    status_clr = 4'b1111; step();
    retire(32'h300);
    chk("t4_index", 64'(hit_index), 0);
    chk("t4_status", 64'(hit_status), 64'b1001);
    halt_and_resume();
    status_clr = 4'b0001; retire(32'h300);
    chk("t4_set_wins", 64'(hit_status), 64'b1001);
    halt_and_resume();
    // asynchronous reset while requesting halt
    cfg(0, 2'b00, 32'h100, 0, 0); cfg(1, 2'b00, 32'h200, 0, 3); trig_en = 4'b0011;
    trig_load = 4'b1111; step();
    retire(32'h200);
    retire(32'h100);
    chk("t6_req", 64'(halt_req), 1);
    #2 rst_n = 0;
    #1;
    chk("t6_async_req", 64'(halt_req), 0);
    chk("t6_async_status", 64'(hit_status), 0);
    chk("t6_async_halted", 64'(halted), 0);
    @(negedge clk); rst_n = 1;
    retire(32'h200); chk("t6_cnt1", 64'(halt_req), 0);
    retire(32'h200); chk("t6_cnt2", 64'(halt_req), 0);
    retire(32'h200); chk("t6_cnt3", 64'(halt_req), 1);
    // randomized traffic; the model compare covers every cycle
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 39) == 0) begin
        trig_en = 4'($urandom);
        for (int i = 0; i < 4; i++)
          cfg(i, 2'($urandom), pool[$urandom_range(0, 7)],
              ($urandom_range(0, 2) == 0) ? 32'h0 : ($urandom_range(0, 1) ? 32'hf : 32'hff),
              16'($urandom_range(0, 3)));
      end
      instr_valid = 1'($urandom); pc = pool[$urandom_range(0, 7)];
      mem_valid = 1'($urandom); mem_we = 1'($urandom); mem_addr = pool[$urandom_range(0, 7)];
      halt_ack = ($urandom_range(0, 3) == 0);
      resume_req = ($urandom_range(0, 4) == 0);
      trig_load = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'b0;
      status_clr = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0;
      step();
    end
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule

// File: doc/rv32i_trigger_unit.md
Name: rv32i_trigger_unit

Overview:
- Parametrised debug trigger unit, the successor to the two-slot PC breakpoint comparator.
- Provides NUM_TRIG channels. Each channel has an address/mask comparator, a selectable match type (execute, load, store or any access) and a hit-count threshold.
- Owns the halt handshake with the CPU core: registered halt request, halted state, and resume with step-over of the breakpointed instruction.
- Sits between the APB debug register slave (configuration and status) and the core's retire/LSU interfaces.

Parameters:
- XLEN, 32, address width.
- NUM_TRIG, 4, number of trigger channels (1..8).
- CNT_W, 16, hit-count threshold and counter width.
- IDX_W, $clog2(NUM_TRIG) (min 1), width of hit_index.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- instr_valid  in  1  instruction retiring this cycle.
- pc  in  XLEN  PC of the retiring instruction.
- mem_valid  in  1  data access issued this cycle.
- mem_we  in  1  1 = store, 0 = load.
- mem_addr  in  XLEN  data access address.
- trig_en  in  NUM_TRIG  per-channel enable.
- trig_type  in  2*NUM_TRIG  per-channel type: 00 exec, 01 load, 10 store, 11 any access.
- trig_addr  in  XLEN*NUM_TRIG  per-channel match address.
- trig_mask  in  XLEN*NUM_TRIG  per-channel don't-care bits (1 = ignore).
- trig_count  in  CNT_W*NUM_TRIG  per-channel hits required to fire (0 is treated as 1).
- trig_load  in  NUM_TRIG  pulse: clear the channel's hit counter.
- status_clr  in  NUM_TRIG  write-1-to-clear for hit_status.
- halt_ack  in  1  core has stopped.
- resume_req  in  1  pulse: debugger requests resume.
- halt_req  out  1  request to the core to halt.
- halted  out  1  core is in the debug-halted state.
- hit_status  out  NUM_TRIG  sticky per-channel fired flags.
- hit_index  out  IDX_W  lowest channel that caused the last halt.
- hit_addr  out  XLEN  address (PC or mem_addr) that caused the last halt.

Behaviour:
- Reset: all outputs 0, all counters 0, FSM in RUN.
- Match, channel i:
  - Condition: trig_en[i], and ((a & ~mask) == (addr & ~mask)).
  - exec: a = pc, qualified by instr_valid.
  - load: a = mem_addr, qualified by mem_valid & ~mem_we.
  - store: a = mem_addr, qualified by mem_valid & mem_we.
  - any: load or store.
- Counting:
  - A match in the RUN state (and a non-suppressed match in SKIP) is a qualified match.
  - On a qualified match, fire when cnt+1 >= max(trig_count,1); on fire, cnt clears to 0.
  - Otherwise cnt increments. Saturate at all-ones, never wrap.
  - trig_load[i] clears cnt; it takes priority over a same-cycle match, and that match is not counted.
- Fire, cycle t:
  - hit_status bits of all firing channels set at t+1.
  - hit_index latches the lowest firing index.
  - hit_addr latches the comparator input of that channel.
  - halt_req rises at t+1 (one-cycle registered latency).
- hit_status: set has priority over a same-cycle status_clr. Clear is honoured in any FSM state.
- FSM states:
  - RUN -> HALT_REQ on any fire.
  - HALT_REQ: halt_req=1, held until halt_ack=1; then -> HALTED. Matches are ignored and counters frozen.
  - HALTED: halted=1, halt_req=0. Matches are ignored. resume_req -> SKIP. halt_ack level is don't-care.
  - SKIP: halted=0. Exec-type matches are suppressed for the first instr_valid (the breakpointed instruction is stepped over). Load/store matches are evaluated normally and may fire, going straight to HALT_REQ. After that instr_valid -> RUN.
- Ignored inputs: halt_ack in RUN or SKIP; resume_req outside HALTED.
- A fire in the same cycle as an instr_valid in SKIP: fire wins -> HALT_REQ.
- Config changes take effect combinationally on the next compare.
- Config changes do not clear counters; only trig_load does.
- Reset mid-halt: returns to RUN with halt_req=0 and halted=0 immediately (asynchronous).

Decomposition:
- rv32i_pkg additions:
  - trig_type_e {TRIG_EXEC, TRIG_LOAD, TRIG_STORE, TRIG_ANY}.
  - dbg_state_e {DBG_RUN, DBG_HALT_REQ, DBG_HALTED, DBG_SKIP}.
  - Default constants NUM_TRIG_DEF and TRIG_CNT_W.
- Sub-module rv32i_trig_channel: one comparator plus its hit counter, instantiated NUM_TRIG times via generate.
- The top level holds the FSM, priority encode, sticky status and capture registers.

Test Plan:
- Exec trigger 0: addr 0x100, mask 0, count 0. Retire pc=0x100 at cycle t -> halt_req=1 at t+1; hit_index=0, hit_addr=0x100, hit_status=0001. halt_ack -> halted=1, halt_req=0.
- Count threshold: ch1 exec at 0x200, count=3. Retire 0x200 three times -> fires on the third only; counter back to 0; the fourth and fifth retires do not fire.
- Mask/store: ch2 store, addr 0x8000_0000, mask 0xFF. Store to 0x8000_0044 -> fire, hit_addr=0x8000_0044. A load to the same address and a store to 0x8000_0100 -> no fire.
- Priority: ch0 and ch3 match the same pc -> hit_index=0, hit_status=1001. status_clr=0001 in the same cycle as a new ch0 fire -> bit 0 stays 1.
- Resume step-over: halted at pc 0x100 -> resume_req -> retire 0x100 does not fire. The next retire at 0x100 (loop) -> fires.
- Reset mid-operation: assert rst_n=0 in HALT_REQ with halt_ack=0 -> halt_req=0 and hit_status=0 asynchronously; counters return to 0.
